// File: rtl/dlx_fetch_stage.sv
// DLX instruction-fetch front end: drives the synchronous instruction memory and presents one word per cycle over valid/ready.
// Optional feature HALT_DETECT_EN: an accepted opcode 6'h3F parks fetch in HALT until reset or program load.
module dlx_fetch_stage #(
   parameter int                ADDR_W   = 16,
   parameter int                INSTR_W  = 32,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic               clock_in,
   input  logic               rst_n,
   input  logic               wr_a,
   output logic               imem_rd_en,
   output logic [ADDR_W-1:0]  imem_addr,
   input  logic [INSTR_W-1:0] imem_rdata,
   output logic               if_valid,
   output logic [INSTR_W-1:0] if_instr,
   output logic [ADDR_W-1:0]  if_pc,
   input  logic               ex_ready,
   input  logic               br_taken,
   input  logic [ADDR_W-1:0]  br_target
);

`ifdef HALT_DETECT_EN
   typedef enum logic [1:0] {S_IDLE, S_RUN, S_HALT} state_t;
`else
   typedef enum logic {S_IDLE, S_RUN} state_t;
`endif

   state_t             r_state;
   logic [ADDR_W-1:0]  r_pc;
   logic [ADDR_W-1:0]  r_pending_pc;
   logic [ADDR_W-1:0]  r_skid_pc;
   logic [INSTR_W-1:0] r_skid_instr;
   logic               r_pending;
   logic               r_skid_valid;

   logic w_run;
   logic w_accept;
   logic w_halt_hit;
   logic w_stall;

   assign w_run    = (r_state == S_RUN) && !wr_a;
   assign if_valid = w_run & (r_skid_valid | r_pending) & ~br_taken;
   assign if_instr = r_skid_valid ? r_skid_instr : imem_rdata;
   assign if_pc    = r_skid_valid ? r_skid_pc : r_pending_pc;
   assign w_accept = if_valid & ex_ready;

`ifdef HALT_DETECT_EN
   assign w_halt_hit = w_accept & (if_instr[INSTR_W-1 -: 6] == 6'h3F);
`else
   assign w_halt_hit = 1'b0;
`endif

   // Skid and pending are never both full, so ex_ready alone covers both
   // "accept the live word and refill" and "skid drained, resume issue".
   assign imem_rd_en = w_run & ~w_halt_hit &
                       (br_taken | ex_ready | ~(r_skid_valid | r_pending));
   assign imem_addr  = (w_run & br_taken) ? br_target : r_pc;
   assign w_stall    = w_run & r_pending & ~ex_ready & ~r_skid_valid & ~br_taken;

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clock_in) begin
      if (!rst_n || wr_a) begin
         r_state      <= S_IDLE;
         r_pc         <= RESET_PC;
         r_pending    <= 1'b0;
         r_skid_valid <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: r_state <= S_RUN;
            S_RUN: begin
               r_pending <= imem_rd_en;
               if (imem_rd_en)
                  r_pc <= imem_addr + 1'b1;
               if (br_taken)
                  r_skid_valid <= 1'b0;
               else if (w_stall)
                  r_skid_valid <= 1'b1;
               else if (r_skid_valid && ex_ready)
                  r_skid_valid <= 1'b0;
`ifdef HALT_DETECT_EN
               if (w_halt_hit) begin
                  r_state      <= S_HALT;
                  r_pending    <= 1'b0;
                  r_skid_valid <= 1'b0;
               end
`endif
            end
            default: ;
         endcase
      end
   end

   // NOTE: payload registers carry no reset; their valid flags above gate
   // every use, so reset only needs to clear control state.
   always_ff @(posedge clock_in) begin
      if (imem_rd_en)
         r_pending_pc <= imem_addr;
      if (w_stall) begin
         r_skid_instr <= imem_rdata;
         r_skid_pc    <= r_pending_pc;
      end
   end

endmodule
